de_ex_pipe: RTL and testbench

- Parametrised decode-to-execute pipeline stage for the 5-stage RV core.
- Registers the decoded bundle (pc, pcn, register indices, operands, control word) into the EX stage using a valid/ready handshake.
- Adds load-use hazard detection with bubble insertion, branch flush, WB-to-ID write bypass, and an operand refresh for instructions held in EX.
- Sits between the decoder/register file and the ALU stage.

---
 rtl/de_ex_pipe.sv | 150 +++++++++++++++
 tb/tb_de_ex_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/de_ex_pipe.sv
// ID->EX pipeline register with load-use stall, branch flush, WB bypass and held-operand refresh.
// Define DE_PERF_CNT_EN to add the saturating stall_cnt/flush_cnt outputs.
module de_ex_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CTRL_W     = 16,
   parameter int REG_AW     = 5
`ifdef DE_PERF_CNT_EN
   ,
   parameter int CNT_W      = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [ADDR_WIDTH-1:0] id_pc,
   input  logic [ADDR_WIDTH-1:0] id_pcn,
   input  logic [REG_AW-1:0]     id_rs1,
   input  logic [REG_AW-1:0]     id_rs2,
   input  logic [REG_AW-1:0]     id_rd,
   input  logic                  id_rs1_need,
   input  logic                  id_rs2_need,
   input  logic [DATA_WIDTH-1:0] id_rd1,
   input  logic [DATA_WIDTH-1:0] id_rd2,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic                  id_reg_we,
   input  logic                  id_is_load,
   input  logic                  wew,
   input  logic [REG_AW-1:0]     rdw,
   input  logic [DATA_WIDTH-1:0] wdw,
   input  logic                  flush,
   input  logic                  ex_ready,
   output logic                  ex_valid,
   output logic [ADDR_WIDTH-1:0] ex_pc,
   output logic [ADDR_WIDTH-1:0] ex_pcn,
   output logic [REG_AW-1:0]     ex_rs1,
   output logic [REG_AW-1:0]     ex_rs2,
   output logic [REG_AW-1:0]     ex_rd,
   output logic [DATA_WIDTH-1:0] ex_rd1,
   output logic [DATA_WIDTH-1:0] ex_rd2,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic                  ex_reg_we,
   output logic                  ex_is_load,
   output logic                  hazard
`ifdef DE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
`endif
);

   logic adv;
   logic load;
   logic hold;
   logic src_hit;

   logic [1:0][REG_AW-1:0]     id_src;
   logic [1:0]                 id_need;
   logic [1:0][DATA_WIDTH-1:0] id_data;
   logic [1:0][REG_AW-1:0]     ex_src;
   logic [1:0][DATA_WIDTH-1:0] ex_opnd;

   assign id_src  = {id_rs2, id_rs1};
   assign id_need = {id_rs2_need, id_rs1_need};
   assign id_data = {id_rd2, id_rd1};
   assign ex_src  = {ex_rs2, ex_rs1};

   assign src_hit = (id_need[0] && id_src[0] == ex_rd) || (id_need[1] && id_src[1] == ex_rd);
   assign hazard  = id_valid && ex_valid && ex_is_load && ex_reg_we && (ex_rd != '0) && src_hit;
   assign adv      = !ex_valid || ex_ready;
   assign id_ready = flush || (adv && !hazard);
   assign load     = !flush && adv && id_valid && !hazard;
   assign hold     = !flush && ex_valid && !ex_ready;

   // Operand lanes: WB bypass on capture, and refresh while the instruction sits in EX.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         logic                  id_byp;
         logic                  ex_byp;
         logic [DATA_WIDTH-1:0] opnd_reg;

         assign id_byp = wew && (rdw != '0) && (rdw == id_src[gi]);
         assign ex_byp = wew && (rdw != '0) && (rdw == ex_src[gi]);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               opnd_reg <= '0;
            end else if (load) begin
               opnd_reg <= id_byp ? wdw : id_data[gi];
            end else if (hold && ex_byp) begin
               opnd_reg <= wdw;
            end
         end

         assign ex_opnd[gi] = opnd_reg;
      end
   endgenerate

   assign ex_rd1 = ex_opnd[0];
   assign ex_rd2 = ex_opnd[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_pcn     <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_ctrl    <= '0;
         ex_reg_we  <= 1'b0;
         ex_is_load <= 1'b0;
      end else begin
         if (flush) begin
            ex_valid <= 1'b0;
         end else if (adv) begin
            ex_valid <= id_valid && !hazard;
         end
         if (load) begin
            ex_pc      <= id_pc;
            ex_pcn     <= id_pcn;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_ctrl    <= id_ctrl;
            ex_reg_we  <= id_reg_we;
            ex_is_load <= id_is_load;
         end
      end
   end

`ifdef DE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazard && !flush && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush && (ex_valid || id_valid) && flush_cnt != '1) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_de_ex_pipe.sv
// Scoreboard bench for de_ex_pipe: directed ID stimulus, expected EX bundles queued on acceptance.
module tb_de_ex_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_pcn;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rs1_need, id_rs2_need;
   logic [31:0] id_rd1, id_rd2;
   logic [15:0] id_ctrl;
   logic        id_reg_we, id_is_load;
   logic        wew;
   logic [4:0]  rdw;
   logic [31:0] wdw;
   logic        flush, ex_ready, ex_valid;
   logic [31:0] ex_pc, ex_pcn;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [31:0] ex_rd1, ex_rd2;
   logic [15:0] ex_ctrl;
   logic        ex_reg_we, ex_is_load, hazard;
`ifdef DE_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   de_ex_pipe dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_pcn(id_pcn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_need(id_rs1_need), .id_rs2_need(id_rs2_need), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_ctrl(id_ctrl), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
      .wew(wew), .rdw(rdw), .wdw(wdw), .flush(flush), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pcn(ex_pcn), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_ctrl(ex_ctrl),
      .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .hazard(hazard)
`ifdef DE_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, pcn;
      logic [4:0]  rs1, rs2, rd;
      logic        n1, n2;
      logic [31:0] rd1, rd2;
      logic [15:0] ctrl;
      logic        we, ld;
   } ins_t;

   ins_t sb[$];
   ins_t cur;
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic n1,
                               input logic [4:0] rs2, input logic n2, input logic [4:0] rd,
                               input logic we, input logic ld);
      ins_t i;
      i.pc = pc; i.pcn = pc + 32'd4;
      i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.n1 = n1; i.n2 = n2;
      i.rd1 = pc ^ 32'h1000_0001; i.rd2 = pc ^ 32'h2000_0002;
      i.ctrl = pc[15:0] ^ 16'h3C3C; i.we = we; i.ld = ld;
      return i;
   endfunction

   task automatic put(input ins_t i);
      cur = i;
      id_valid = 1'b1; id_pc = i.pc; id_pcn = i.pcn;
      id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
      id_rs1_need = i.n1; id_rs2_need = i.n2;
      id_rd1 = i.rd1; id_rd2 = i.rd2; id_ctrl = i.ctrl;
      id_reg_we = i.we; id_is_load = i.ld;
   endtask

   task automatic idle();
      id_valid = 1'b0;
   endtask

   // One clock: check handshake, queue an accepted instruction, retire what EX hands over.
   task automatic tick(input string tag, input logic exp_hz, input logic exp_rdy);
      ins_t e;
      #1;
      check({tag, ".hazard"}, 64'(hazard), 64'(exp_hz));
      check({tag, ".id_ready"}, 64'(id_ready), 64'(exp_rdy));
      if (id_valid && exp_rdy && !flush) begin
         e = cur;
         if (wew && rdw != 5'd0 && rdw == cur.rs1) e.rd1 = wdw;
         if (wew && rdw != 5'd0 && rdw == cur.rs2) e.rd2 = wdw;
         sb.push_back(e);
      end
      if (ex_valid && (ex_ready || flush)) begin
         check({tag, ".sb_pending"}, 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (flush) begin
               $display("txn %s killed pc=0x%0h", tag, e.pc);
            end else begin
               $display("txn %s retire pc=0x%0h rd1=0x%0h rd2=0x%0h", tag, ex_pc, ex_rd1, ex_rd2);
               check({tag, ".pc"}, 64'(ex_pc), 64'(e.pc));
               check({tag, ".pcn"}, 64'(ex_pcn), 64'(e.pcn));
               check({tag, ".regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'({e.rs1, e.rs2, e.rd}));
               check({tag, ".rd1"}, 64'(ex_rd1), 64'(e.rd1));
               check({tag, ".rd2"}, 64'(ex_rd2), 64'(e.rd2));
               check({tag, ".ctrl"}, 64'(ex_ctrl), 64'(e.ctrl));
               check({tag, ".flags"}, 64'({ex_reg_we, ex_is_load}), 64'({e.we, e.ld}));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      ins_t i;
      id_valid = 0; id_pc = 0; id_pcn = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rs1_need = 0; id_rs2_need = 0; id_rd1 = 0; id_rd2 = 0; id_ctrl = 0;
      id_reg_we = 0; id_is_load = 0; wew = 0; rdw = 0; wdw = 0; flush = 0; ex_ready = 1;

      repeat (2) @(posedge clk);
      #1;
      check("rst.ex_valid", 64'(ex_valid), 64'(0));
      check("rst.ex_pc", 64'(ex_pc), 64'(0));
      check("rst.ex_rd1", 64'(ex_rd1), 64'(0));
      check("rst.ex_ctrl", 64'(ex_ctrl), 64'(0));
      rst = 1'b1;

      // back-to-back independent instructions
      put(mk(32'h0, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0)); tick("t1a", 0, 1);
      check("t1a.ex_valid", 64'(ex_valid), 64'(1)); check("t1a.ex_pc", 64'(ex_pc), 64'h0);
      put(mk(32'h4, 5'd1, 1, 5'd2, 1, 5'd11, 1, 0)); tick("t1b", 0, 1);
      check("t1b.ex_valid", 64'(ex_valid), 64'(1)); check("t1b.ex_pc", 64'(ex_pc), 64'h4);
      put(mk(32'h8, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0)); tick("t1c", 0, 1);
      check("t1c.ex_valid", 64'(ex_valid), 64'(1)); check("t1c.ex_pc", 64'(ex_pc), 64'h8);
      idle(); tick("t1d", 0, 1);
      check("t1d.ex_valid", 64'(ex_valid), 64'(0));

      // load-use on rs1: one bubble
      put(mk(32'h10, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1)); tick("t2ld", 0, 1);
      put(mk(32'h14, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0)); tick("t2hz", 1, 0);
      check("t2.bubble", 64'(ex_valid), 64'(0));
      tick("t2go", 0, 1);
      check("t2.enter", 64'(ex_valid), 64'(1)); check("t2.pc", 64'(ex_pc), 64'h14);
      idle(); tick("t2d", 0, 1);

      // load-use on rs2 while the load is also held in EX
      put(mk(32'h20, 5'd1, 1, 5'd0, 0, 5'd9, 1, 1)); tick("t2b_ld", 0, 1);
      put(mk(32'h24, 5'd0, 0, 5'd9, 1, 5'd13, 1, 0));
      ex_ready = 0; tick("t2b_h1", 1, 0);
      ex_ready = 1; tick("t2b_h2", 1, 0);
      check("t2b.bubble", 64'(ex_valid), 64'(0));
      tick("t2b_go", 0, 1);
      idle(); tick("t2b_d", 0, 1);

      // x0 destination and unused sources never stall
      put(mk(32'h30, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1)); tick("t3ld", 0, 1);
      put(mk(32'h34, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0)); tick("t3x0", 0, 1);
      check("t3.nobubble", 64'(ex_valid), 64'(1)); check("t3.pc", 64'(ex_pc), 64'h34);
      put(mk(32'h38, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1)); tick("t3ld5", 0, 1);
      put(mk(32'h3C, 5'd5, 0, 5'd5, 0, 5'd15, 1, 0)); tick("t3nn", 0, 1);
      check("t3nn.ex_valid", 64'(ex_valid), 64'(1));
      idle(); tick("t3d", 0, 1);

      // WB bypass on capture, both operands, and never for x0
      i = mk(32'h40, 5'd3, 1, 5'd3, 1, 5'd16, 1, 0); i.rd1 = 32'h11; i.rd2 = 32'h22;
      put(i); wew = 1; rdw = 5'd3; wdw = 32'hDEAD; tick("t4", 0, 1);
      check("t4.ex_rd1", 64'(ex_rd1), 64'hDEAD); check("t4.ex_rd2", 64'(ex_rd2), 64'hDEAD);
      i = mk(32'h44, 5'd0, 1, 5'd0, 0, 5'd17, 1, 0); i.rd1 = 32'h55;
      put(i); rdw = 5'd0; wdw = 32'h99; tick("t4z", 0, 1);
      check("t4z.ex_rd1", 64'(ex_rd1), 64'h55);
      wew = 0; idle(); tick("t4d", 0, 1);

      // held-operand refresh, then flushes
      i = mk(32'h50, 5'd1, 1, 5'd7, 1, 5'd18, 1, 0); i.rd2 = 32'h5;
      put(i); tick("t5ld", 0, 1);
      idle(); ex_ready = 0; wew = 1; rdw = 5'd7; wdw = 32'h1234; tick("t5hold", 0, 0);
      check("t5.ex_rd2", 64'(ex_rd2), 64'h1234); check("t5.ex_rd1", 64'(ex_rd1), 64'(i.rd1));
      check("t5.ex_valid", 64'(ex_valid), 64'(1));
      wew = 0; flush = 1; put(mk(32'h54, 5'd1, 1, 5'd2, 1, 5'd19, 1, 0)); tick("t5fl", 0, 1);
      check("t5fl.ex_valid", 64'(ex_valid), 64'(0));
      ex_ready = 1; tick("t5fl2", 0, 1);
      check("t5fl2.ex_valid", 64'(ex_valid), 64'(0));
      idle(); tick("t5fl3", 0, 1);
      flush = 0;
`ifdef DE_PERF_CNT_EN
      check("cnt.stall", 64'(stall_cnt), 64'd3);
      check("cnt.flush", 64'(flush_cnt), 64'd2);
`endif

      // asynchronous reset mid-stream
      put(mk(32'h60, 5'd1, 1, 5'd2, 1, 5'd20, 1, 1)); tick("t6ld", 0, 1);
      check("t6.ex_valid_pre", 64'(ex_valid), 64'(1));
      #2 rst = 1'b0;
      #1;
      check("t6.ex_valid", 64'(ex_valid), 64'(0));
      check("t6.ex_pc", 64'(ex_pc), 64'(0));
      check("t6.ex_ops", 64'({ex_rd1, ex_rd2}), 64'(0));
      check("t6.ex_misc", 64'({ex_ctrl, ex_rd, ex_reg_we, ex_is_load}), 64'(0));
`ifdef DE_PERF_CNT_EN
      check("t6.cnts", 64'({stall_cnt, flush_cnt}), 64'(0));
`endif
      sb.delete();
      idle();
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      put(mk(32'h70, 5'd1, 1, 5'd2, 1, 5'd21, 1, 0)); tick("t6re", 0, 1);
      check("t6re.pc", 64'(ex_pc), 64'h70);
      idle(); tick("t6d", 0, 1);
      check("end.sb_empty", 64'(sb.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
